// File: rtl/pll_supervisor.sv
// PLL supervisor: sequences PLL reset, waits for a stable lock and
// gates the system reset, with retry, fault and loss-of-lock tracking.
module pll_supervisor #(
    parameter int RESET_PULSE_CYCLES  = 4,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       clear_flags,
    output logic       pll_resetb,
    output logic       rst_out_n,
    output logic       ready,
    output logic       lock_lost,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [7:0] loss_count
);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             lock_s;
    logic [1:0]       retry_q, retry_d, retry_inc;
    logic [7:0]       loss_q, loss_d;
    logic             lost_q, lost_d, lost_set;
    logic             pll_resetb_q, pll_resetb_d;
    logic             run_q, run_d;
    logic             fault_q, fault_d;

    assign lock_s    = sync2_q;
    assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        retry_d  = retry_q;
        loss_d   = loss_q;
        lost_set = 1'b0;
        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    retry_d = retry_inc;
                    state_d = (int'(retry_inc) == MAX_RETRIES) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                    retry_d = 2'd0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d  = PLL_RST;
                    lost_set = 1'b1;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so the registers track state_q.
    always_comb begin
        pll_resetb_d = !((state_d == PLL_RST) || (state_d == FAULT));
        run_d        = (state_d == RUN);
        fault_d      = (state_d == FAULT);
        if (lost_set) lost_d = 1'b1;
        else if (clear_flags) lost_d = 1'b0;
        else lost_d = lost_q;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            retry_q      <= 2'd0;
            loss_q       <= 8'd0;
            lost_q       <= 1'b0;
            pll_resetb_q <= 1'b0;
            run_q        <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync1_q      <= locked;
            sync2_q      <= sync1_q;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            lost_q       <= lost_d;
            pll_resetb_q <= pll_resetb_d;
            run_q        <= run_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb  = pll_resetb_q;
    assign rst_out_n   = run_q;
    assign ready       = run_q;
    assign lock_lost   = lost_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor with params 4/16/8/3.
module tb_pll_supervisor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       locked = 1'b0;
    logic       clear_flags = 1'b0;
    logic       pll_resetb, rst_out_n, ready, lock_lost, fault;
    logic [1:0] retry_count;
    logic [7:0] loss_count;
    int         vecs = 0;
    int         errs = 0;

    pll_supervisor #(
        .RESET_PULSE_CYCLES (4),
        .LOCK_TIMEOUT_CYCLES(16),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (3),
        .CNT_W              (16)
    ) dut (
        .clock_in   (clk),
        .reset_n    (reset_n),
        .locked     (locked),
        .clear_flags(clear_flags),
        .pll_resetb (pll_resetb),
        .rst_out_n  (rst_out_n),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .fault      (fault),
        .retry_count(retry_count),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves reset released just after an edge; the next edge is edge 1.
    task automatic do_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        vecs++;
        if ({pll_resetb, rst_out_n, ready, lock_lost, fault} !== 5'b0) begin
            errs++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {pll_resetb, rst_out_n, ready, lock_lost, fault});
        end
        vecs++;
        if ({retry_count, loss_count} !== 10'd0) begin
            errs++;
            $display("FAIL reset_counts got=%0d/%0d exp=0/0",
                     retry_count, loss_count);
        end
    endtask

    task automatic test_startup();
        locked = 1'b0;
        do_reset();
        step(3);
        vecs++;
        if (pll_resetb !== 1'b0) begin
            errs++;
            $display("FAIL start_pulse_e3 got=%b exp=0", pll_resetb);
        end
        step(1);
        vecs++;
        if (pll_resetb !== 1'b1) begin
            errs++;
            $display("FAIL start_pulse_e4 got=%b exp=1", pll_resetb);
        end
        step(5);
        locked = 1'b1;
        step(10);
        vecs++;
        if (ready !== 1'b0) begin
            errs++;
            $display("FAIL start_ready_e19 got=%b exp=0", ready);
        end
        step(1);
        vecs++;
        if ({ready, rst_out_n, fault, retry_count} !== 5'b11000) begin
            errs++;
            $display("FAIL start_run_e20 got=%b exp=11000",
                     {ready, rst_out_n, fault, retry_count});
        end
    endtask

    task automatic test_no_lock();
        locked = 1'b0;
        do_reset();
        step(20);
        vecs++;
        if ({retry_count, pll_resetb} !== 3'b010) begin
            errs++;
            $display("FAIL nolock_e20 got=%b exp=010",
                     {retry_count, pll_resetb});
        end
        step(4);
        vecs++;
        if (pll_resetb !== 1'b1) begin
            errs++;
            $display("FAIL nolock_e24 got=%b exp=1", pll_resetb);
        end
        step(16);
        vecs++;
        if ({retry_count, pll_resetb} !== 3'b100) begin
            errs++;
            $display("FAIL nolock_e40 got=%b exp=100",
                     {retry_count, pll_resetb});
        end
        step(19);
        vecs++;
        if ({fault, retry_count, pll_resetb} !== 4'b0101) begin
            errs++;
            $display("FAIL nolock_e59 got=%b exp=0101",
                     {fault, retry_count, pll_resetb});
        end
        step(1);
        vecs++;
        if ({fault, retry_count, pll_resetb, ready} !== 5'b11100) begin
            errs++;
            $display("FAIL nolock_fault got=%b exp=11100",
                     {fault, retry_count, pll_resetb, ready});
        end
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        step(30);
        vecs++;
        if ({fault, retry_count, pll_resetb, rst_out_n} !== 5'b11100) begin
            errs++;
            $display("FAIL nolock_hold got=%b exp=11100",
                     {fault, retry_count, pll_resetb, rst_out_n});
        end
    endtask

    task automatic test_glitch();
        locked = 1'b1;
        do_reset();
        step(8);
        locked = 1'b0;
        step(3);
        locked = 1'b1;
        step(2);
        vecs++;
        if ({ready, pll_resetb} !== 2'b01) begin
            errs++;
            $display("FAIL glitch_e13 got=%b exp=01", {ready, pll_resetb});
        end
        step(8);
        vecs++;
        if (ready !== 1'b0) begin
            errs++;
            $display("FAIL glitch_e21 got=%b exp=0", ready);
        end
        step(1);
        vecs++;
        if ({ready, retry_count} !== 3'b100) begin
            errs++;
            $display("FAIL glitch_e22 got=%b exp=100", {ready, retry_count});
        end
    endtask

    task automatic test_loss();
        step(2);
        locked = 1'b0;
        step(2);
        vecs++;
        if (ready !== 1'b1) begin
            errs++;
            $display("FAIL loss_early got=%b exp=1", ready);
        end
        step(1);
        vecs++;
        if ({ready, rst_out_n, lock_lost, pll_resetb} !== 4'b0010 ||
            loss_count !== 8'd1) begin
            errs++;
            $display("FAIL loss_fall got=%b/%0d exp=0010/1",
                     {ready, rst_out_n, lock_lost, pll_resetb}, loss_count);
        end
        locked = 1'b1;
        step(3);
        vecs++;
        if (pll_resetb !== 1'b0) begin
            errs++;
            $display("FAIL loss_pulse_end got=%b exp=0", pll_resetb);
        end
        step(1);
        vecs++;
        if (pll_resetb !== 1'b1) begin
            errs++;
            $display("FAIL loss_pulse_rel got=%b exp=1", pll_resetb);
        end
        step(8);
        vecs++;
        if (ready !== 1'b0) begin
            errs++;
            $display("FAIL loss_relock_early got=%b exp=0", ready);
        end
        step(1);
        vecs++;
        if ({ready, lock_lost, retry_count} !== 4'b1100) begin
            errs++;
            $display("FAIL loss_relock got=%b exp=1100",
                     {ready, lock_lost, retry_count});
        end
    endtask

    task automatic test_back_to_back();
        step(2);
        locked = 1'b0;
        step(2);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        vecs++;
        if ({lock_lost, ready} !== 2'b10 || loss_count !== 8'd2) begin
            errs++;
            $display("FAIL simul_set_wins got=%b/%0d exp=10/2",
                     {lock_lost, ready}, loss_count);
        end
        locked = 1'b1;
        step(13);
        vecs++;
        if ({ready, lock_lost} !== 2'b11) begin
            errs++;
            $display("FAIL simul_relock got=%b exp=11", {ready, lock_lost});
        end
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        vecs++;
        if ({lock_lost, ready} !== 2'b01 || loss_count !== 8'd2) begin
            errs++;
            $display("FAIL simul_clear got=%b/%0d exp=01/2",
                     {lock_lost, ready}, loss_count);
        end
    endtask

    task automatic test_mid_reset();
        step(2);
        locked = 1'b0;
        step(3);
        vecs++;
        if ({lock_lost, ready} !== 2'b10 || loss_count !== 8'd3) begin
            errs++;
            $display("FAIL mid_loss got=%b/%0d exp=10/3",
                     {lock_lost, ready}, loss_count);
        end
        locked = 1'b1;
        step(8);
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({pll_resetb, rst_out_n, ready, lock_lost, fault} !== 5'b0 ||
            {retry_count, loss_count} !== 10'd0) begin
            errs++;
            $display("FAIL mid_async got=%b/%0d/%0d exp=00000/0/0",
                     {pll_resetb, rst_out_n, ready, lock_lost, fault},
                     retry_count, loss_count);
        end
        step(1);
        reset_n = 1'b1;
        step(3);
        vecs++;
        if (pll_resetb !== 1'b0) begin
            errs++;
            $display("FAIL mid_pulse_e3 got=%b exp=0", pll_resetb);
        end
        step(1);
        vecs++;
        if (pll_resetb !== 1'b1) begin
            errs++;
            $display("FAIL mid_pulse_e4 got=%b exp=1", pll_resetb);
        end
        step(8);
        vecs++;
        if (ready !== 1'b0) begin
            errs++;
            $display("FAIL mid_ready_e12 got=%b exp=0", ready);
        end
        step(1);
        vecs++;
        if ({ready, rst_out_n} !== 2'b11) begin
            errs++;
            $display("FAIL mid_ready_e13 got=%b exp=11", {ready, rst_out_n});
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_no_lock();
        test_glitch();
        test_loss();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
